alu_rr_arbiter: RTL and testbench

- Shares one 8-bit add/shift-left ALU datapath between two requesters using round-robin arbitration.
- Each requester presents operands and an op bit on a valid/ready channel.
- The block captures one request, executes it in the ALU, registers the result and returns it on a single response channel tagged with the requester id.
- Sits between the decode/issue stages and the shared ALU; only one operation is in flight at a time.

---
 rtl/alu_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared add/shift-left ALU.
// One operation in flight at a time: IDLE (grant) -> EXEC (compute) -> RESP (hold result).
module alu_rr_arbiter #(
   parameter int   WIDTH  = 8,
   parameter logic OP_SHL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_in1,
   input  logic [WIDTH-1:0] req0_in2,
   input  logic             req0_op,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_in1,
   input  logic [WIDTH-1:0] req1_in2,
   input  logic             req1_op,
   output logic             req1_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_id,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic [WIDTH-1:0] in1_q, in1_d;
   logic [WIDTH-1:0] in2_q, in2_d;
   logic             op_q, op_d;
   logic             id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_id_q, rsp_id_d;

   logic             grant;
   logic [WIDTH-1:0] alu_result;

   // A lone valid requester always wins; prio only breaks ties.
   always_comb begin
      if (req0_valid && req1_valid) grant = prio_q;
      else                          grant = req1_valid;
   end

   assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
   assign req1_ready = (state_q == IDLE) &&  grant && req1_valid;

   // Shift amounts at or beyond WIDTH flush to zero; the full in2 value is compared.
   always_comb begin
      if (op_q == OP_SHL) alu_result = (in2_q >= SHIFT_LIMIT) ? '0 : (in1_q << in2_q);
      else                alu_result = in1_q + in2_q;
   end

   always_comb begin
      // NOTE: every _d defaults to its _q first so no branch can leave a latch behind.
      state_d      = state_q;
      prio_d       = prio_q;
      in1_d        = in1_q;
      in2_d        = in2_q;
      op_d         = op_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_id_d     = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               in1_d   = grant ? req1_in1 : req0_in1;
               in2_d   = grant ? req1_in2 : req0_in2;
               op_d    = grant ? req1_op  : req0_op;
               id_d    = grant;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_id_d     = id_q;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               prio_d      = ~id_q;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         in1_q        <= '0;
         in2_q        <= '0;
         op_q         <= 1'b0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         in1_q        <= in1_d;
         in2_q        <= in2_d;
         op_q         <= op_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_id     = rsp_id_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: reset, arithmetic corners, stalls, round-robin fairness, reset mid-op.
module tb_alu_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_op, req0_ready;
   logic [7:0] req0_in1, req0_in2;
   logic       req1_valid, req1_op, req1_ready;
   logic [7:0] req1_in1, req1_in2;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] rsp_result;

   int n_cmp = 0;
   int n_err = 0;

   alu_rr_arbiter #(.WIDTH(8), .OP_SHL(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_op = 1'b0;
      req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_op = 1'b0;
      rsp_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0)  begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      n_cmp++; if (rsp_result !== 8'h00) begin n_err++; $display("FAIL reset_rsp_result got %h want 00", rsp_result); end
      n_cmp++; if (rsp_id !== 1'b0)     begin n_err++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
   endtask

   // One operation from a single requester; optional consumer stall with both requesters knocking.
   task automatic test_op(input string nm, input bit id, input logic [7:0] a, input logic [7:0] b,
                          input bit op, input int stall, input logic [7:0] exp);
      if (id) begin req1_valid = 1'b1; req1_in1 = a; req1_in2 = b; req1_op = op; end
      else    begin req0_valid = 1'b1; req0_in1 = a; req0_in2 = b; req0_op = op; end
      rsp_ready = (stall == 0);
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01))
         begin n_err++; $display("FAIL %s_grant got r1r0=%b want id %0d", nm, {req1_ready, req0_ready}, id); end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      n_cmp++; if ({rsp_valid, busy} !== 2'b01) begin n_err++; $display("FAIL %s_exec got valid,busy=%b want 01", nm, {rsp_valid, busy}); end
      tick();
      n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, id, exp})
         begin n_err++; $display("FAIL %s_rsp got v=%b id=%b res=%h want v=1 id=%b res=%h", nm, rsp_valid, rsp_id, rsp_result, id, exp); end
      if (stall > 0) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         for (int i = 0; i < stall; i++) begin
            tick();
            n_cmp++; if ({rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready} !== {1'b1, id, exp, 2'b00})
               begin n_err++; $display("FAIL %s_stall%0d got v=%b id=%b res=%h rdy=%b%b want held, no ready", nm, i, rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready); end
         end
         req0_valid = 1'b0; req1_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      tick();
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL %s_done got valid,busy=%b want 00", nm, {rsp_valid, busy}); end
   endtask

   task automatic test_arith();
      test_op("add_basic", 1'b0, 8'h0F, 8'h01, 1'b0, 0, 8'h10);
      test_op("shl_stall", 1'b1, 8'h03, 8'd2,  1'b1, 3, 8'h0C);
      test_op("shl_by8",   1'b1, 8'h03, 8'd8,  1'b1, 3, 8'h00);
      test_op("add_wrap",  1'b0, 8'hFF, 8'h02, 1'b0, 0, 8'h01);
      test_op("shl_trunc", 1'b1, 8'h81, 8'd1,  1'b1, 0, 8'h02);
      test_op("shl_by9",   1'b0, 8'h01, 8'd9,  1'b1, 0, 8'h00);
      test_op("shl_by7",   1'b0, 8'h7F, 8'd7,  1'b1, 0, 8'h80);
   endtask

   // Both requesters valid continuously; grants must alternate 0,1,0,1 from reset.
   task automatic test_round_robin();
      logic [7:0] exp;
      rst = 1'b1; tick(); rst = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_in1 = 8'd10; req0_in2 = 8'd20; req0_op = 1'b0;
      req1_valid = 1'b1; req1_in1 = 8'h05; req1_in2 = 8'd3;  req1_op = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp = (k % 2 == 1) ? 8'h28 : 8'h1E;
         n_cmp++; if ({req1_ready, req0_ready, rsp_valid} !== {k % 2 == 1, k % 2 == 0, 1'b0})
            begin n_err++; $display("FAIL rr_grant%0d got r1r0=%b%b v=%b want id %0d", k, req1_ready, req0_ready, rsp_valid, k % 2); end
         tick();
         n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rr_exec_ready%0d got %b want 00", k, {req0_ready, req1_ready}); end
         tick();
         n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, k % 2 == 1, exp})
            begin n_err++; $display("FAIL rr_rsp%0d got v=%b id=%b res=%h want id=%0d res=%h", k, rsp_valid, rsp_id, rsp_result, k % 2, exp); end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
   endtask

   // Lone requester 1 served repeatedly, then a tie must go to requester 0.
   task automatic test_lone_then_tie();
      test_op("lone1_a", 1'b1, 8'h01, 8'h01, 1'b0, 0, 8'h02);
      test_op("lone1_b", 1'b1, 8'h02, 8'd4,  1'b1, 0, 8'h20);
      test_op("lone1_c", 1'b1, 8'h80, 8'h80, 1'b0, 0, 8'h00);
      req0_valid = 1'b1; req0_in1 = 8'h33; req0_in2 = 8'h44; req0_op = 1'b0;
      req1_valid = 1'b1; req1_in1 = 8'h01; req1_in2 = 8'd1;  req1_op = 1'b1;
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL tie_after_1 got r1r0=%b want 01", {req1_ready, req0_ready}); end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 8'h77})
         begin n_err++; $display("FAIL tie_rsp got v=%b id=%b res=%h want v=1 id=0 res=77", rsp_valid, rsp_id, rsp_result); end
      tick();
   endtask

   // Reset while a response is held; prio was 1 beforehand, so a tie afterwards proves prio cleared.
   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_in1 = 8'h11; req0_in2 = 8'h22; req0_op = 1'b0;
      #1;
      tick();
      req0_valid = 1'b0;
      tick();
      n_cmp++; if ({rsp_valid, rsp_result} !== {1'b1, 8'h33}) begin n_err++; $display("FAIL mid_pre got v=%b res=%h want v=1 res=33", rsp_valid, rsp_result); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if ({rsp_valid, busy, rsp_id, rsp_result} !== {1'b0, 1'b0, 1'b0, 8'h00})
         begin n_err++; $display("FAIL mid_reset got v=%b busy=%b id=%b res=%h want all 0", rsp_valid, busy, rsp_id, rsp_result); end
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_in1 = 8'h05; req0_in2 = 8'h06; req0_op = 1'b0;
      req1_valid = 1'b1; req1_in1 = 8'h01; req1_in2 = 8'd2;  req1_op = 1'b1;
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL mid_prio got r1r0=%b want 01", {req1_ready, req0_ready}); end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 8'h0B})
         begin n_err++; $display("FAIL mid_after got v=%b id=%b res=%h want v=1 id=0 res=0b", rsp_valid, rsp_id, rsp_result); end
      tick();
      n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_err++; $display("FAIL mid_done got valid,busy=%b want 00", {rsp_valid, busy}); end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_round_robin();
      test_lone_then_tie();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
